// File: rtl/ram_7x1_queue_ctrl.sv
// 1-bit FIFO controller driving an external DEPTH x 1 RAM macro (combinational read, posedge write); RAM_7X1_QUEUE_FLOW_EN adds empty flow-through.
// Latency: enq to deq_valid 1 cycle (0 with flow-through when empty).
// Backpressure: enq_ready drops when full or in reset; deq_valid holds head until deq_ready.
module ram_7x1_queue_ctrl #(
  parameter int DEPTH  = 7,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic              enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic              deq_bits,
  output logic [2:0]        count,
  output logic [ADDR_W-1:0] ram_R0_addr,
  output logic              ram_R0_en,
  output logic              ram_R0_clk,
  input  logic              ram_R0_data,
  output logic [ADDR_W-1:0] ram_W0_addr,
  output logic              ram_W0_en,
  output logic              ram_W0_clk,
  output logic              ram_W0_data
);

  localparam logic [2:0]        DEPTH_C = 3'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic              full;
  logic              empty;
  logic              flow_vld;
  logic              flow_thru;
  logic              enq_fire;
  logic              deq_fire;
  logic              wr;
  logic              rd;

  // Wrap at DEPTH-1 so addresses beyond the last entry are never driven.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == DEPTH_C);
  assign empty = (count == 3'd0);

`ifdef RAM_7X1_QUEUE_FLOW_EN
  assign flow_vld = reset_n & empty & enq_valid;
`else
  assign flow_vld = 1'b0;
`endif
  // A flow-through beat bypasses the RAM entirely: no write, no pointer motion.
  assign flow_thru = flow_vld & deq_ready;

  assign enq_ready = reset_n & !full;
  assign deq_valid = !empty | flow_vld;
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;
  assign wr        = enq_fire & !flow_thru;
  assign rd        = deq_fire & !flow_thru & !empty;

  assign ram_W0_clk  = clock;
  assign ram_W0_en   = wr;
  assign ram_W0_addr = tail;
  assign ram_W0_data = enq_bits;

  assign ram_R0_clk  = clock;
  assign ram_R0_en   = deq_valid;
  assign ram_R0_addr = head;
  assign deq_bits    = !empty ? ram_R0_data : (flow_vld ? enq_bits : 1'b0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= 3'd0;
    end else begin
      if (wr) tail <= next_ptr(tail);
      if (rd) head <= next_ptr(head);
      case ({wr, rd})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/ram_7x1_queue_ctrl.md
Name: ram_7x1_queue_ctrl

Overview:
- Synchronous FIFO controller that acts as the initiator for an external 7-entry x 1-bit RAM macro, driving its R0 and W0 port groups.
- The macro's read is combinational: R0_data follows R0_addr while R0_en=1. Its write is at posedge W0_clk when W0_en=1.
- Presents ready/valid enqueue and dequeue interfaces to the BOOM-side logic.
- Instantiated next to the RAM macro wherever a 1-bit, 7-deep queue is needed.

Parameters:
- DEPTH, 7, number of RAM entries; valid range 2..7.
- ADDR_W, 3, RAM address width; 2^ADDR_W >= DEPTH.

Ports:
- clock  in  1  block clock; also forwarded to both RAM clocks.
- reset_n  in  1  asynchronous, active-low reset.
- enq_valid  in  1  producer has data.
- enq_ready  out  1  queue can accept.
- enq_bits  in  1  data to enqueue.
- deq_valid  out  1  queue has data.
- deq_ready  in  1  consumer accepts.
- deq_bits  out  1  head data.
- count  out  3  occupancy, 0..DEPTH.
- ram_R0_addr  out  ADDR_W  RAM read address.
- ram_R0_en  out  1  RAM read enable.
- ram_R0_clk  out  1  equals clock.
- ram_R0_data  in  1  RAM read data, combinational from addr.
- ram_W0_addr  out  ADDR_W  RAM write address.
- ram_W0_en  out  1  RAM write enable.
- ram_W0_clk  out  1  equals clock.
- ram_W0_data  out  1  RAM write data.

Behaviour:
- Clock and reset: one clock domain, clock. Reset is asynchronous and active-low on reset_n.
- State: head and tail are ADDR_W-bit registers; count is a 3-bit register. All three clear to 0 immediately when reset_n falls.
- Outputs while reset_n=0: enq_ready=0, deq_valid=0, ram_W0_en=0, ram_R0_en=0, deq_bits=0, count=0.
- full = (count==DEPTH). empty = (count==0).
- enq_ready = reset_n & !full.
- deq_valid = !empty.
- enq_fire = enq_valid & enq_ready. deq_fire = deq_valid & deq_ready.
- Write path (combinational):
  - ram_W0_en = enq_fire.
  - ram_W0_addr = tail.
  - ram_W0_data = enq_bits.
  - The entry is written at the same edge that advances tail.
- Read path (combinational):
  - ram_R0_en = deq_valid.
  - ram_R0_addr = head.
  - deq_bits = deq_valid ? ram_R0_data : 0. The RAM's X is never propagated.
- Pointer advance: on fire, the pointer goes to (ptr==DEPTH-1) ? 0 : ptr+1. Wrap is at DEPTH-1, not at 2^ADDR_W-1; address 7 is never driven.
- count update each cycle, plus enq_fire, minus deq_fire:
  - both fire: count unchanged; head and tail both advance.
  - neither fires: no change.
- Full: enq_ready=0, so a simultaneous enq and deq while full performs the deq only. enq_ready returns to 1 on the next cycle.
- Empty: deq_valid=0, so the enq only. Latency from enq_fire to deq_valid is 1 cycle.
- Read/write address collision (head==tail with count in 1..DEPTH-1) cannot occur. head==tail occurs only when empty or full, and neither case has a concurrent write-and-read of live data.
- Reset mid-operation: RAM contents are not cleared. They are treated as stale and become unreachable because count=0.
- No illegal state: count never exceeds DEPTH. Pointers are always < DEPTH.

Optional Feature:
- Macro: RAM_7X1_QUEUE_FLOW_EN.
- Defined: flow-through when empty.
  - If empty & enq_valid: deq_valid=1 and deq_bits=enq_bits.
  - If deq_ready is also 1: ram_W0_en=0, tail, head and count are unchanged, and enq_ready=1.
  - If deq_ready=0: a normal enqueue with the write.
- Not defined: deq_valid is strictly !empty, and enqueue-to-dequeue latency is at least 1 cycle.

Test Plan:
- Reset then idle:
  - Release reset_n. Expect enq_ready=1, deq_valid=0, count=0, ram_W0_en=0, deq_bits=0.
- Fill to full:
  - Enqueue 1,0,1,1,0,0,1 on 7 consecutive cycles. Expect ram_W0_addr sequence 0..6 and count=7.
  - Expect enq_ready=0 afterwards. An 8th enq_valid causes no write.
- Drain and wrap:
  - From full, dequeue 7 times. Expect deq_bits 1,0,1,1,0,0,1 and ram_R0_addr 0..6.
  - Then enqueue 0. Expect ram_W0_addr=0, with head and tail both wrapped from 6 to 0.
- Simultaneous enq and deq:
  - At count=3, hold both fires for 10 cycles. Expect count to stay 3 and addresses to wrap 6 to 0, never driving 7.
  - Expect data order preserved.
- Full with both valid:
  - At count=7, assert enq_valid and deq_ready. Expect a dequeue only, count=6, then enq_ready=1 on the next cycle.
- Asynchronous reset mid-stream:
  - At count=4, pulse reset_n low between clock edges. Expect count=0 and deq_valid=0 immediately.
  - The next enqueue writes address 0.
- With RAM_7X1_QUEUE_FLOW_EN, while empty:
  - enq_valid=1, enq_bits=1, deq_ready=1: expect same-cycle deq_valid=1, deq_bits=1, ram_W0_en=0, count stays 0.
